serial_byte_aligner: RTL

Receive-side deserializer. It sits directly upstream of the parallel receiver/demux stage. It takes the single-bit line stream in the clk_32f domain and finds byte alignment by searching for COM (K28.5, 0xBC) characters. After COM_COUNT consecutive aligned COMs it declares lock and delivers one 8-bit byte plus a valid flag every 8 clocks, together with a lock indicator (active) for the downstream lane demux.

---
 rtl/serial_byte_aligner.sv | 76 +++++++
 1 files changed

// File: rtl/serial_byte_aligner.sv
// serial_byte_aligner: serial-to-byte deserializer that locks onto COM characters.
// Once locked it delivers one aligned byte and strobe every 8 bit clocks.
module serial_byte_aligner #(
  parameter logic [7:0] COM = 8'hBC,
  parameter logic [7:0] IDLE = 8'h7C,
  parameter int COM_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);
  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] ALIGNING = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);
  logic [1:0] state;
  logic [7:0] sr;
  logic [7:0] nb;
  logic [2:0] bit_cnt;
  logic [3:0] com_cnt;
  logic [3:0] com_cnt_nx;
  logic       is_com;
  logic       boundary;
  always_comb begin
    nb = {sr[6:0], data_in};
    is_com = nb == COM;
    boundary = bit_cnt == 3'd7;
    com_cnt_nx = com_cnt + 4'd1;
  end
  assign active = state == LOCKED;
  // Search is bit-granular only while unlocked; afterwards the bit counter fixes the phase.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state <= UNLOCKED;
      sr <= 8'h00;
      bit_cnt <= 3'd0;
      com_cnt <= 4'd0;
      data_out <= 8'h00;
      valid_out <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      sr <= nb;
      byte_strobe <= 1'b0;
      case (state)
        UNLOCKED: if (is_com) begin
          bit_cnt <= 3'd0;
          com_cnt <= 4'd1;
          state <= COM_TARGET == 4'd1 ? LOCKED : ALIGNING;
        end
        ALIGNING: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary && is_com) begin
            com_cnt <= com_cnt_nx;
            if (com_cnt_nx == COM_TARGET) state <= LOCKED;
          end else if (boundary) begin
            com_cnt <= 4'd0;
            state <= UNLOCKED;
          end
        end
        LOCKED: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            data_out <= nb;
            valid_out <= !is_com && nb != IDLE;
            byte_strobe <= 1'b1;
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end
endmodule
